sram_like_data_slave: RTL and testbench

- Responder end of the sram-like data interface that the data caches drive on their memory side (req/wr/size/addr/wdata out, addr_ok/data_ok/rdata back).
- Word-addressed data memory with a two-phase handshake: address acceptance, then in-order data completion.
- Programmable address and data latencies and a bounded outstanding-request queue.
- Used as the memory behind the d-cache in unit and system benches, and as an on-chip scratch RAM.

---
 rtl/sram_like_data_slave.sv | 128 ++++++++++++
 tb/tb_sram_like_data_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_data_slave.sv
// Responder for the sram-like data interface: word memory behind a two-phase
// handshake with programmable address/data latency and an in-order request queue.
module sram_like_data_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned ADDR_LAT    = 1,
  parameter int unsigned DATA_LAT    = 2,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
);

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CD_W  = 4;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [CD_W-1:0]       cd;
  } entry_t;

  entry_t                r_q     [QUEUE_DEPTH];
  entry_t                w_q_nxt [QUEUE_DEPTH];
  logic [CNT_W-1:0]      r_count;
  logic [CD_W-1:0]       r_wait_cnt;
  logic [31:0]           r_mem   [WORDS];

  logic                  w_accept;
  logic                  w_pop;
  logic [3:0]            w_be;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [PTR_W-1:0]      w_push_slot;
  entry_t                w_head;
  logic                  w_unused;

  // Upper address bits alias onto the same words.
  assign w_idx    = data_addr[ADDR_WIDTH+1:2];
  assign w_unused = ^data_addr[31:ADDR_WIDTH+2];

  assign w_head       = r_q[0];
  assign w_pop        = (r_count != '0) && (w_head.cd == '0);
  assign data_addr_ok = data_req
                      && ((5'(r_wait_cnt) + 5'd1) > 5'(ADDR_LAT))
                      && (r_count < CNT_W'(QUEUE_DEPTH));
  assign w_accept     = data_req && data_addr_ok;
  assign w_push_slot  = PTR_W'(r_count - CNT_W'(w_pop));

  always_comb begin
    w_be = 4'b1111;
    case (data_size)
      2'd0:    w_be = 4'b0001 << data_addr[1:0];
      2'd1:    w_be = data_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Age every entry, shift out the retired head, then append the new request.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_q_nxt[i]    = r_q[i];
      w_q_nxt[i].cd = (r_q[i].cd == '0) ? '0 : r_q[i].cd - CD_W'(1);
    end
    if (w_pop) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
        w_q_nxt[i]    = r_q[i+1];
        w_q_nxt[i].cd = (r_q[i+1].cd == '0) ? '0 : r_q[i+1].cd - CD_W'(1);
      end
      w_q_nxt[QUEUE_DEPTH-1] = '0;
    end
    if (w_accept) begin
      w_q_nxt[w_push_slot] = '{wr:    data_wr,
                               idx:   w_idx,
                               be:    w_be,
                               wdata: data_wdata,
                               cd:    CD_W'(DATA_LAT - 1)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_wait_cnt   <= '0;
      data_data_ok <= 1'b0;
      data_rdata   <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
      r_q     <= w_q_nxt;
      if (w_accept || !data_req) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != '1) begin
        r_wait_cnt <= r_wait_cnt + CD_W'(1);
      end
      data_data_ok <= w_pop;
      data_rdata   <= (w_pop && !w_head.wr) ? r_mem[w_head.idx] : '0;
    end
  end

  // Writes land at retirement, so a read retiring next cycle already sees them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_pop && w_head.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_head.be[b]) begin
          r_mem[w_head.idx][8*b +: 8] <= w_head.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Bench for sram_like_data_slave: directed handshake/lane/reset cases plus
// randomized traffic against a transaction-level reference model.
module tb_sram_like_data_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_wr, a_aok, a_dok;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_wr, b_aok, b_dok;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_like_data_slave #(.ADDR_WIDTH(10), .ADDR_LAT(1), .DATA_LAT(2), .QUEUE_DEPTH(2)) u_dut_a (
    .clk(clk), .rst(rst), .data_req(a_req), .data_wr(a_wr), .data_size(a_size),
    .data_addr(a_addr), .data_wdata(a_wdata), .data_rdata(a_rdata),
    .data_addr_ok(a_aok), .data_data_ok(a_dok));

  sram_like_data_slave #(.ADDR_WIDTH(10), .ADDR_LAT(0), .DATA_LAT(3), .QUEUE_DEPTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .data_req(b_req), .data_wr(b_wr), .data_size(b_size),
    .data_addr(b_addr), .data_wdata(b_wdata), .data_rdata(b_rdata),
    .data_addr_ok(b_aok), .data_data_ok(b_dok));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    a_req = 1'b0; a_wr = 1'b0; a_size = 2'd2; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_size = 2'd2; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one request on instance A and waits for its completion (bounded).
  task automatic xact(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, output int n_wait, output int lat,
                      output logic [31:0] rd, output bit ok);
    ok = 1'b0; n_wait = 0; lat = 0; rd = '0;
    a_req = 1'b1; a_wr = wr; a_size = size; a_addr = addr; a_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_wait++;
      if (a_aok) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin a_req = 1'b0; return; end
    @(posedge clk); #1 a_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_dok) begin rd = a_rdata; ok = 1'b1; break; end
      @(posedge clk); lat++;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0:    return 32'h0000_00FF << {addr[1:0], 3'b000};
      2'd1:    return 32'h0000_FFFF << {addr[1], 4'b0000};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++; if (a_aok !== 1'b0) begin miscompares++; $display("FAIL reset_addr_ok got %b exp 0", a_aok); end
    vectors++; if (a_dok !== 1'b0) begin miscompares++; $display("FAIL reset_data_ok got %b exp 0", a_dok); end
    vectors++; if (a_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", a_rdata); end
    vectors++; if (b_dok !== 1'b0) begin miscompares++; $display("FAIL reset_b_data_ok got %b exp 0", b_dok); end
    @(posedge clk); #1;
  endtask

  task automatic test_first_read();
    int nw, lat; logic [31:0] rd; bit ok;
    do_reset();
    xact(1'b0, 2'd2, 32'h0000_0010, 32'h0, nw, lat, rd, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL first_read_timeout got %b exp 1", ok); end
    vectors++; if (nw != 2) begin miscompares++; $display("FAIL first_read_addr_ok_cycle got %0d exp 2", nw); end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL first_read_latency got %0d exp 2", lat); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL first_read_rdata got %h exp 0", rd); end
  endtask

  task automatic test_byte_lanes();
    int nw, lat; logic [31:0] rd; bit ok;
    do_reset();
    xact(1'b1, 2'd2, 32'h20, 32'hDEAD_BEEF, nw, lat, rd, ok);
    vectors++; if (!ok || lat != 2) begin miscompares++; $display("FAIL word_write_done got ok=%b lat=%0d exp ok=1 lat=2", ok, lat); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL word_write_rdata got %h exp 0", rd); end
    xact(1'b1, 2'd0, 32'h21, 32'hAAAA_AAAA, nw, lat, rd, ok);
    vectors++; if (!ok || lat != 2) begin miscompares++; $display("FAIL byte_write_done got ok=%b lat=%0d exp ok=1 lat=2", ok, lat); end
    xact(1'b0, 2'd2, 32'h20, 32'h0, nw, lat, rd, ok);
    vectors++; if (!ok || rd !== 32'hDEAD_AAEF) begin miscompares++; $display("FAIL byte_merge_read got %h exp deadaaef", rd); end
  endtask

  task automatic test_half();
    int nw, lat; logic [31:0] rd; bit ok;
    do_reset();
    xact(1'b1, 2'd1, 32'h42, 32'h1234_5678, nw, lat, rd, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL half_write_timeout got %b exp 1", ok); end
    xact(1'b0, 2'd2, 32'h40, 32'h0, nw, lat, rd, ok);
    vectors++; if (!ok || rd !== 32'h1234_0000) begin miscompares++; $display("FAIL half_merge_read got %h exp 12340000", rd); end
  endtask

  task automatic test_alias();
    int nw, lat; logic [31:0] rd; bit ok;
    do_reset();
    xact(1'b1, 2'd2, 32'h0000_1004, 32'hCAFE_F00D, nw, lat, rd, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL alias_write_timeout got %b exp 1", ok); end
    xact(1'b0, 2'd2, 32'h0000_0004, 32'h0, nw, lat, rd, ok);
    vectors++; if (!ok || rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL alias_read got %h exp cafef00d", rd); end
  endtask

  task automatic test_reset_drop();
    int nw, lat; logic [31:0] rd; bit ok; bit seen;
    do_reset();
    a_req = 1'b1; a_wr = 1'b1; a_size = 2'd2; a_addr = 32'h80; a_wdata = 32'h55;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_aok) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL drop_accept_timeout got %b exp 1", ok); end
    @(posedge clk); #1 a_req = 1'b0; rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_dok) seen = 1'b1;
      @(posedge clk); #1;
      if (i == 1) rst = 1'b0;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL dropped_write_data_ok got %b exp 0", seen); end
    xact(1'b0, 2'd2, 32'h80, 32'h0, nw, lat, rd, ok);
    vectors++; if (!ok || rd !== 32'h0) begin miscompares++; $display("FAIL dropped_write_read got %h exp 0", rd); end
  endtask

  // Instance B: ADDR_LAT=0, DATA_LAT=3, depth 2, req held high across six requests.
  task automatic test_back_to_back();
    logic [31:0] addrs [6]; logic wrs [6]; logic [31:0] wd [6]; logic [31:0] exp_rd [6];
    int exp_done [6] = '{4, 5, 8, 9, 12, 13};
    int qd [$]; logic [31:0] qr [$]; int done_at [$];
    int t, acc, last_done, stalls, got;
    bit exp_aok, exp_dok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      addrs[i] = 32'h100 + 32'(4 * i); wrs[i] = 1'b1; wd[i] = $urandom; exp_rd[i] = '0;
      addrs[i+3] = addrs[i]; wrs[i+3] = 1'b0; wd[i+3] = $urandom; exp_rd[i+3] = wd[i];
    end
    t = 0; acc = 0; last_done = 0; stalls = 0;
    b_req = 1'b1; b_wr = wrs[0]; b_size = 2'd2; b_addr = addrs[0]; b_wdata = wd[0];
    while (t < 60 && (acc < 6 || qd.size() != 0)) begin
      @(negedge clk);
      exp_dok = (qd.size() != 0) && (qd[0] == t);
      vectors++; if (b_dok !== exp_dok) begin miscompares++; $display("FAIL b2b_data_ok cyc %0d got %b exp %b", t, b_dok, exp_dok); end
      if (exp_dok) begin
        vectors++; if (b_rdata !== qr[0]) begin miscompares++; $display("FAIL b2b_rdata cyc %0d got %h exp %h", t, b_rdata, qr[0]); end
        done_at.push_back(t);
        void'(qd.pop_front()); void'(qr.pop_front());
      end
      exp_aok = b_req && (qd.size() < 2);
      vectors++; if (b_aok !== exp_aok) begin miscompares++; $display("FAIL b2b_addr_ok cyc %0d got %b exp %b", t, b_aok, exp_aok); end
      if (b_req && !b_aok) stalls++;
      if (exp_aok) begin
        last_done = (t + 4 > last_done + 1) ? t + 4 : last_done + 1;
        qd.push_back(last_done); qr.push_back(exp_rd[acc]);
        acc++;
      end
      @(posedge clk); t++; #1;
      if (acc < 6) begin
        b_req = 1'b1; b_wr = wrs[acc]; b_addr = addrs[acc]; b_wdata = wd[acc];
      end else begin
        b_req = 1'b0;
      end
    end
    vectors++; if (stalls != 4) begin miscompares++; $display("FAIL b2b_stall_cycles got %0d exp 4", stalls); end
    for (int i = 0; i < 6; i++) begin
      got = (i < done_at.size()) ? done_at[i] : -1;
      vectors++; if (got != exp_done[i]) begin miscompares++; $display("FAIL b2b_done_cycle[%0d] got %0d exp %0d", i, got, exp_done[i]); end
    end
  endtask

  task automatic rand_fields();
    a_wr    = 1'($urandom_range(0, 1));
    a_size  = 2'($urandom_range(0, 3));
    a_addr  = ($urandom & 32'hFFFF_F000) | {20'd0, 6'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    a_wdata = $urandom;
  endtask

  // Instance A under random traffic; model applies requests in accept order.
  task automatic test_random();
    logic [31:0] mm [1024];
    int qd [$]; logic [31:0] qr [$];
    int t, last_done, wait_m, idx;
    bit exp_aok, exp_dok, acc;
    logic [31:0] m, rd;
    do_reset();
    for (int i = 0; i < 1024; i++) mm[i] = '0;
    t = 0; last_done = 0; wait_m = 0;
    a_req = ($urandom_range(0, 3) != 0); rand_fields();
    while (t < 600 && (t < 400 || qd.size() != 0)) begin
      @(negedge clk);
      exp_dok = (qd.size() != 0) && (qd[0] == t);
      vectors++; if (a_dok !== exp_dok) begin miscompares++; $display("FAIL rand_data_ok cyc %0d got %b exp %b", t, a_dok, exp_dok); end
      if (exp_dok) begin
        vectors++; if (a_rdata !== qr[0]) begin miscompares++; $display("FAIL rand_rdata cyc %0d got %h exp %h", t, a_rdata, qr[0]); end
        void'(qd.pop_front()); void'(qr.pop_front());
      end
      exp_aok = a_req && (wait_m >= 1) && (qd.size() < 2);
      vectors++; if (a_aok !== exp_aok) begin miscompares++; $display("FAIL rand_addr_ok cyc %0d got %b exp %b", t, a_aok, exp_aok); end
      acc = exp_aok;
      if (acc) begin
        idx = int'(a_addr[11:2]);
        m = lane_mask(a_size, a_addr);
        if (a_wr) begin
          mm[idx] = (mm[idx] & ~m) | (a_wdata & m);
          rd = '0;
        end else begin
          rd = mm[idx];
        end
        last_done = (t + 3 > last_done + 1) ? t + 3 : last_done + 1;
        qd.push_back(last_done); qr.push_back(rd);
        wait_m = 0;
      end else if (a_req) begin
        wait_m = (wait_m < 15) ? wait_m + 1 : 15;
      end else begin
        wait_m = 0;
      end
      @(posedge clk); t++; #1;
      if (t >= 400) begin
        a_req = 1'b0;
      end else if (acc || !a_req) begin
        a_req = ($urandom_range(0, 3) != 0); rand_fields();
      end else begin
        rand_fields();
      end
    end
    vectors++; if (qd.size() != 0) begin miscompares++; $display("FAIL rand_drain_pending got %0d exp 0", qd.size()); end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_byte_lanes();
    test_half();
    test_back_to_back();
    test_reset_drop();
    test_alias();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
